// File: rtl/spi_reg_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : spi_reg_ctrl_if
// Purpose  : SPI pin bundle (sclk/copi/ncs) between an SPI master and the
//            register controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface spi_reg_ctrl_if;
  logic sclk;
  logic copi;
  logic ncs;

  modport master (output sclk, output copi, output ncs);
  modport slave  (input  sclk, input  copi, input  ncs);
endinterface

`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
//------------------------------------------------------------------------------
// Module   : spi_reg_ctrl
// Purpose  : SPI-slave write-only register file holding the PWM configuration.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module spi_reg_ctrl #(
  parameter int MAX_ADDR    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic       clk,
  input  wire logic       rst,
  spi_reg_ctrl_if.slave   spi,
  output logic [7:0]      en_reg_out_7_0,
  output logic [7:0]      en_reg_out_15_8,
  output logic [7:0]      en_reg_pwm_7_0,
  output logic [7:0]      en_reg_pwm_15_8,
  output logic [7:0]      pwm_duty_cycle,
  output logic            frame_done,
  output logic            frame_err
);

  localparam logic [1:0] ST_WAIT_HIGH = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;
  localparam logic [1:0] ST_COMMIT    = 2'd3;

  localparam int                  SETTLE_W    = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES);
  localparam logic [6:0]          MAX_ADDR_7  = 7'(MAX_ADDR);

  // Top bit of each edge-detected pipe is the history flop.
  logic [SYNC_STAGES:0]   r_sclk_pipe;
  logic [SYNC_STAGES:0]   r_ncs_pipe;
  logic [SYNC_STAGES-1:0] r_copi_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_pipe <= '0;
      r_ncs_pipe  <= '1;
    end else begin
      r_sclk_pipe <= {r_sclk_pipe[SYNC_STAGES-1:0], spi.sclk};
      r_ncs_pipe  <= {r_ncs_pipe[SYNC_STAGES-1:0], spi.ncs};
    end
  end

  generate
    if (SYNC_STAGES == 1) begin : g_copi_single
      always_ff @(posedge clk) begin
        if (rst) r_copi_pipe <= '0;
        else     r_copi_pipe <= spi.copi;
      end
    end else begin : g_copi_chain
      always_ff @(posedge clk) begin
        if (rst) r_copi_pipe <= '0;
        else     r_copi_pipe <= {r_copi_pipe[SYNC_STAGES-2:0], spi.copi};
      end
    end
  endgenerate

  logic w_sclk_rise, w_ncs_fall, w_ncs_rise, w_ncs_high, w_copi;
  assign w_sclk_rise = r_sclk_pipe[SYNC_STAGES-1] & ~r_sclk_pipe[SYNC_STAGES];
  assign w_ncs_fall  = ~r_ncs_pipe[SYNC_STAGES-1] &  r_ncs_pipe[SYNC_STAGES];
  assign w_ncs_rise  =  r_ncs_pipe[SYNC_STAGES-1] & ~r_ncs_pipe[SYNC_STAGES];
  assign w_ncs_high  =  r_ncs_pipe[SYNC_STAGES-1];
  assign w_copi      =  r_copi_pipe[SYNC_STAGES-1];

  // The ncs chain resets to 1, so its output is stale until the pin value has
  // propagated; without this, ncs held low across reset would look like a fresh
  // falling edge and capture the tail of the interrupted frame.
  logic [SETTLE_W-1:0] r_settle;
  logic                w_settled;
  assign w_settled = (r_settle == SETTLE_DONE);

  always_ff @(posedge clk) begin
    if (rst)             r_settle <= '0;
    else if (!w_settled) r_settle <= r_settle + 1'b1;
  end

  logic [1:0]  r_state, w_state_next;
  logic [15:0] r_shift;
  logic [4:0]  r_count;
  logic        w_frame_valid;
  logic        w_clear, w_shift, w_commit_ok, w_commit_err;

  assign w_frame_valid = (r_count == 5'd16) && r_shift[15] && (r_shift[14:8] <= MAX_ADDR_7);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_WAIT_HIGH;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_HIGH: if (w_settled && w_ncs_high) w_state_next = ST_IDLE;
      ST_IDLE:      if (w_ncs_fall)              w_state_next = ST_SHIFT;
      ST_SHIFT:     if (w_ncs_rise)              w_state_next = ST_COMMIT;
      ST_COMMIT:                                 w_state_next = ST_IDLE;
      default:                                   w_state_next = ST_WAIT_HIGH;
    endcase
  end

  // sclk edges coinciding with the ncs fall land while still in IDLE and are dropped.
  always_comb begin
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_commit_ok  = 1'b0;
    w_commit_err = 1'b0;
    case (r_state)
      ST_IDLE:   w_clear = w_ncs_fall;
      ST_SHIFT:  w_shift = w_sclk_rise;
      ST_COMMIT: begin
        w_commit_ok  =  w_frame_valid;
        w_commit_err = ~w_frame_valid;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift         <= '0;
      r_count         <= '0;
      frame_done      <= 1'b0;
      frame_err       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      frame_done <= w_commit_ok;
      frame_err  <= w_commit_err;
      if (w_clear) begin
        r_shift <= '0;
        r_count <= '0;
      end else if (w_shift) begin
        r_shift <= {r_shift[14:0], w_copi};
        if (r_count != 5'd17) r_count <= r_count + 5'd1;
      end
      // Valid addresses above 4 have no backing register and only pulse frame_done.
      if (w_commit_ok) begin
        case (r_shift[14:8])
          7'd0:    en_reg_out_7_0  <= r_shift[7:0];
          7'd1:    en_reg_out_15_8 <= r_shift[7:0];
          7'd2:    en_reg_pwm_7_0  <= r_shift[7:0];
          7'd3:    en_reg_pwm_15_8 <= r_shift[7:0];
          7'd4:    pwm_duty_cycle  <= r_shift[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

SPI-slave register controller that configures the PWM peripheral on the TinyTapeout tile. It receives 16-bit write frames from an external SPI master on three asynchronous pins, synchronizes them into the `clk` domain, and drives the five configuration registers that feed the PWM block: output enables, PWM enables and duty cycle. The PWM block has no other configuration path.

## Interface
- `MAX_ADDR`, default 4: highest valid register address; frames addressed above it are discarded.
- `SYNC_STAGES`, default 2: synchronizer flops per SPI input, ahead of the edge-detect flop.
- `clk` in 1: system clock. One clock domain; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `sclk` in 1: SPI clock from the pin, asynchronous.
- `copi` in 1: SPI data in, asynchronous.
- `ncs` in 1: SPI chip select, active-low, asynchronous.
- `en_reg_out_7_0` out 8: register 0x00, output enable for pins 7:0.
- `en_reg_out_15_8` out 8: register 0x01, output enable for pins 15:8.
- `en_reg_pwm_7_0` out 8: register 0x02, PWM-mode enable for pins 7:0.
- `en_reg_pwm_15_8` out 8: register 0x03, PWM-mode enable for pins 15:8.
- `pwm_duty_cycle` out 8: register 0x04, duty cycle. 0x00 = 0 %, 0xFF = 100 %.
- `frame_done` out 1: one-cycle pulse when a frame is committed.
- `frame_err` out 1: one-cycle pulse when a frame is discarded.

## Operation
- SPI mode 0, MSB first. `copi` is sampled on each synchronized `sclk` rising edge.
- Frame format:
  - bit 15: R/W, 1 = write.
  - bits 14:8: address.
  - bits 7:0: data.
- Synchronizers: `SYNC_STAGES` flops per input, followed by one history flop used for edge detection. Reset values are `sclk` = 0, `copi` = 0, `ncs` = 1.
- FSM states:
  - WAIT_HIGH: entered on reset. Moves to IDLE once synchronized `ncs` = 1. This prevents a mid-frame capture if `ncs` is held low across reset.
  - IDLE: a falling edge on synchronized `ncs` clears the shift register and the bit counter, then moves to SHIFT.
  - SHIFT: each `sclk` rising edge shifts in one bit. The counter is 5 bits wide and saturates at 17. A rising edge on `ncs` moves to COMMIT.
  - COMMIT: lasts one cycle, then moves to IDLE. The frame is written only if all three hold: count = 16, bit 15 = 1, and address ≤ `MAX_ADDR`. In that case the addressed register takes the data byte and `frame_done` pulses.
- Any other COMMIT outcome leaves all registers unchanged and pulses `frame_err`. This covers read frames, short frames, long frames and invalid addresses.
- Edges on `sclk` are ignored outside SHIFT.
- If an `sclk` rising edge is detected in the same cycle as the `ncs` falling edge, that `sclk` edge is ignored.
- Writes are write-only: there is no readback, and `uio`/`cipo` is not driven by this block.
- Exactly one register can change per frame. Unaddressed registers hold their value.
- `rst` asserted in any state:
  - all registers return to 0x00;
  - shift register, counter and pulse outputs clear;
  - the FSM returns to WAIT_HIGH;
  - the in-flight frame is discarded with no `frame_err`.

## Timing
- Reset values: all five registers 0x00, `frame_done` 0, `frame_err` 0, FSM in WAIT_HIGH.
- Input latency: a pin edge becomes visible to the FSM `SYNC_STAGES` + 1 `clk` edges after it occurs (setup met).
- Commit latency: with default parameters, the register and `frame_done` update on the 4th rising `clk` edge after `ncs` rises. This is 3 edges to detect the edge plus 1 edge in COMMIT.
- Pulses are exactly one cycle wide. `frame_done` and `frame_err` are never high together.
- SPI constraints:
  - `sclk` high and low times each ≥ `SYNC_STAGES` + 2 `clk` periods.
  - `ncs` high time between frames ≥ `SYNC_STAGES` + 3 `clk` periods.
  - Violating these is undefined, but must not corrupt a register other than the one addressed.
- Back-to-back frames meeting the `ncs` high time are all accepted. No frame is lost while in COMMIT.

## Test plan
- Reset check: assert `rst` for 2 cycles → all five outputs read 0x00, FSM in WAIT_HIGH, no pulses.
- Single write: frame 0x8480 (write, address 0x04, data 0x80) → `pwm_duty_cycle` = 0x80 on the 4th `clk` edge after `ncs` rises; `frame_done` pulses once; the other four registers stay 0x00.
- All registers: frames 0x80F0, 0x81CC, 0x82AA, 0x8355, 0x8401 → registers read F0/CC/AA/55/01; exactly 5 `frame_done` pulses.
- Discarded frames, each → registers unchanged and `frame_err` pulses once:
  - read 0x0433;
  - 15-bit frame;
  - 17-bit frame;
  - address 0x05 (0x8577).
- Reset mid-frame: assert `rst` after 8 bits of 0x8399 while holding `ncs` low through reset, then complete the frame → `en_reg_pwm_15_8` stays 0x00, no pulses. A following clean frame 0x8399 writes 0x99.
- Timing margins: `sclk` at minimum high/low times with back-to-back frames at minimum `ncs` gap → every frame commits, with no spurious `frame_err`.
